// File: rtl/tt_gate_eval_pipe_if.sv
// rtl/tt_gate_eval_pipe_if.sv - configuration and evaluation stream bundle for tt_gate_eval_pipe
// Purpose: groups the table-load handshake, the input vector stream, the result
//          stream and the ones counter into one bundle.
// Ports (signals):
//   cfg_start/cfg_valid/cfg_bit  table load control, driven by master
//   cfg_busy/cfg_done            load status, driven by slave
//   in_valid/in_vec/in_ready     input vector stream (master -> slave)
//   out_valid/out_bit/out_ready  result stream (slave -> master)
//   ones_cnt                     saturating count of accepted 1 results
// Modports: master = stimulus side, slave = evaluator side.

interface tt_gate_eval_pipe_if #(
   parameter int N_IN  = 4,
   parameter int CNT_W = 8
);
   logic              cfg_start;
   logic              cfg_valid;
   logic              cfg_bit;
   logic              cfg_busy;
   logic              cfg_done;
   logic              in_valid;
   logic              in_ready;
   logic [N_IN-1:0]   in_vec;
   logic              out_valid;
   logic              out_ready;
   logic              out_bit;
   logic [CNT_W-1:0]  ones_cnt;

   modport master (
      output cfg_start, cfg_valid, cfg_bit, in_valid, in_vec, out_ready,
      input  cfg_busy, cfg_done, in_ready, out_valid, out_bit, ones_cnt
   );

   modport slave (
      input  cfg_start, cfg_valid, cfg_bit, in_valid, in_vec, out_ready,
      output cfg_busy, cfg_done, in_ready, out_valid, out_bit, ones_cnt
   );
endinterface

// File: rtl/tt_gate_eval_pipe.sv
// rtl/tt_gate_eval_pipe.sv - runtime-loadable N_IN-input truth-table evaluator with output FIFO
// Purpose: looks up in_vec in the active truth table at accept time and queues the
//          result in a DEPTH-entry FIFO; a serial loader fills a shadow table which
//          replaces the active table in a one-cycle COMMIT state.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    tt_gate_eval_pipe_if.slave (cfg_*, in_*, out_*, ones_cnt)

module tt_gate_eval_pipe #(
   parameter int                    N_IN     = 4,
   parameter logic [(1<<N_IN)-1:0]  TT_RESET = 16'h4A32,
   parameter int                    DEPTH    = 2,
   parameter int                    CNT_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   tt_gate_eval_pipe_if.slave   bus
);
   localparam int TT_W = 1 << N_IN;
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW   = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {S_RUN, S_LOAD, S_COMMIT} state_t;

   state_t              state, state_nxt;
   logic [TT_W-1:0]     active;
   logic [TT_W-1:0]     shadow, shadow_nxt;
   logic [N_IN-1:0]     bit_cnt, bit_cnt_nxt;
   logic                busy, commit;

   logic                mem [DEPTH];
   logic [PW-1:0]       wr_ptr, rd_ptr, wr_inc, rd_inc;
   logic [CW-1:0]       count, count_nxt;
   logic                out_valid_q, out_bit_q, head_nxt;
   logic [CNT_W-1:0]    ones_q;
   logic                push, pop, lookup, in_ready;

   // ---------------- table load FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_RUN;
         shadow  <= '0;
         bit_cnt <= '0;
         active  <= TT_RESET;
      end else begin
         state   <= state_nxt;
         shadow  <= shadow_nxt;
         bit_cnt <= bit_cnt_nxt;
         if (commit) active <= shadow;
      end
   end

   always_comb begin
      state_nxt   = state;
      shadow_nxt  = shadow;
      bit_cnt_nxt = bit_cnt;
      busy        = 1'b0;
      commit      = 1'b0;
      case (state)
         S_RUN: begin
            if (bus.cfg_start) begin
               state_nxt   = S_LOAD;
               shadow_nxt  = '0;
               bit_cnt_nxt = '0;
            end
         end
         S_LOAD: begin
            busy = 1'b1;
            // A restart wins over a data bit presented in the same cycle.
            if (bus.cfg_start) begin
               shadow_nxt  = '0;
               bit_cnt_nxt = '0;
            end else if (bus.cfg_valid) begin
               shadow_nxt[bit_cnt] = bus.cfg_bit;
               bit_cnt_nxt         = bit_cnt + 1'b1;
               if (bit_cnt == {N_IN{1'b1}}) state_nxt = S_COMMIT;
            end
         end
         S_COMMIT: begin
            busy      = 1'b1;
            commit    = 1'b1;
            state_nxt = S_RUN;
         end
         default: state_nxt = S_RUN;
      endcase
   end

   // ---------------- evaluation and output FIFO ----------------
   // The bit is looked up at accept time, so a vector accepted in the COMMIT
   // cycle still sees the old table (active updates on that edge).
   assign lookup   = active[bus.in_vec];
   assign pop      = out_valid_q & bus.out_ready;
   assign in_ready = (count < CW'(DEPTH)) | pop;
   assign push     = bus.in_valid & in_ready;
   assign wr_inc   = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
   assign rd_inc   = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

   // out_bit is a register holding the FIFO head; this computes the head after
   // the current cycle's push/pop so it is ready on the next edge.
   always_comb begin
      count_nxt = count;
      head_nxt  = out_bit_q;
      case ({push, pop})
         2'b10: begin
            count_nxt = count + 1'b1;
            if (count == '0) head_nxt = lookup;
         end
         2'b01: begin
            count_nxt = count - 1'b1;
            if (count > CW'(1)) head_nxt = mem[rd_inc];
         end
         2'b11: begin
            if (count > CW'(1)) head_nxt = mem[rd_inc];
            else                head_nxt = lookup;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= lookup;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         out_valid_q <= 1'b0;
         out_bit_q   <= 1'b0;
         ones_q      <= '0;
      end else begin
         if (push) wr_ptr <= wr_inc;
         if (pop)  rd_ptr <= rd_inc;
         count       <= count_nxt;
         out_valid_q <= (count_nxt != '0);
         out_bit_q   <= head_nxt;
         if (push && lookup && (ones_q != {CNT_W{1'b1}})) ones_q <= ones_q + 1'b1;
      end
   end

   assign bus.cfg_busy  = busy;
   assign bus.cfg_done  = commit;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_bit   = out_bit_q;
   assign bus.ones_cnt  = ones_q;
endmodule
